video_timing_gen: RTL and testbench

Parametrised, runtime-reconfigurable raster timing generator for the HDMI output path, in the `clk_pixel` domain. It produces horizontal and vertical sync, data enable, active-area pixel coordinates and frame/line strobes from a programmable timing set. A new timing set is accepted through a valid/ready handshake and takes effect only at a frame boundary. Sync polarity is programmable per axis, and the generator supports clean start and stop on frame boundaries.

---
 rtl/video_timing_gen_if.sv | 40 ++++
 rtl/video_timing_gen.sv | 244 ++++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// -----------------------------------------------------------------------------
// video_timing_gen_if
// Configuration channel of the raster timing generator.
//   cfg_h_* / cfg_v_*   candidate horizontal / vertical timing fields
//   cfg_hpol/cfg_vpol   candidate sync polarities (1 = active-high)
//   cfg_valid           offer of a candidate set (from master)
//   cfg_ready           generator can take a new set (pending slot empty)
//   cfg_err             one-cycle pulse when an offered set is rejected
// -----------------------------------------------------------------------------
interface video_timing_gen_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] cfg_h_active;
    logic [WIDTH-1:0] cfg_h_front;
    logic [WIDTH-1:0] cfg_h_sync;
    logic [WIDTH-1:0] cfg_h_back;
    logic [WIDTH-1:0] cfg_v_active;
    logic [WIDTH-1:0] cfg_v_front;
    logic [WIDTH-1:0] cfg_v_sync;
    logic [WIDTH-1:0] cfg_v_back;
    logic             cfg_hpol;
    logic             cfg_vpol;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_h_active, cfg_h_front, cfg_h_sync, cfg_h_back,
        output cfg_v_active, cfg_v_front, cfg_v_sync, cfg_v_back,
        output cfg_hpol, cfg_vpol, cfg_valid,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_h_active, cfg_h_front, cfg_h_sync, cfg_h_back,
        input  cfg_v_active, cfg_v_front, cfg_v_sync, cfg_v_back,
        input  cfg_hpol, cfg_vpol, cfg_valid,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Runtime-reconfigurable raster timing generator (clk_pixel domain).
// Line/frame order is sync, back porch, active, front porch; count 0 is the
// first sync pixel. New timing sets are held in a one-deep pending slot and
// become active on a frame boundary (or at once while idle).
// Ports:
//   clk_pixel   pixel clock
//   reset       synchronous, active-high
//   enable      run request; dropping it lets the current frame finish
//   cfg         configuration channel (video_timing_gen_if, slave side)
//   x, y        active-area coordinates, 0 outside the active area
//   hsync/vsync polarity-applied syncs
//   de          active-area data enable
//   sof / sol   start-of-frame / start-of-active-line pulses
//   running     high while counting (RUN or DRAIN)
// All outputs are registered from the previous cycle's counters.
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int WIDTH        = 12,
    parameter int H_ACTIVE_RST = 640,
    parameter int H_FRONT_RST  = 16,
    parameter int H_SYNC_RST   = 96,
    parameter int H_BACK_RST   = 48,
    parameter int V_ACTIVE_RST = 480,
    parameter int V_FRONT_RST  = 10,
    parameter int V_SYNC_RST   = 2,
    parameter int V_BACK_RST   = 33,
    parameter bit HPOL_RST     = 1'b0,
    parameter bit VPOL_RST     = 1'b0
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic              enable,
    video_timing_gen_if.slave cfg,
    output logic [WIDTH-1:0]  x,
    output logic [WIDTH-1:0]  y,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              sof,
    output logic              sol,
    output logic              running
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] h_active;
        logic [WIDTH-1:0] h_front;
        logic [WIDTH-1:0] h_sync;
        logic [WIDTH-1:0] h_back;
        logic [WIDTH-1:0] v_active;
        logic [WIDTH-1:0] v_front;
        logic [WIDTH-1:0] v_sync;
        logic [WIDTH-1:0] v_back;
        logic             hpol;
        logic             vpol;
    } timing_t;

    localparam timing_t RST_SET = '{
        h_active: H_ACTIVE_RST[WIDTH-1:0], h_front: H_FRONT_RST[WIDTH-1:0],
        h_sync:   H_SYNC_RST[WIDTH-1:0],   h_back:  H_BACK_RST[WIDTH-1:0],
        v_active: V_ACTIVE_RST[WIDTH-1:0], v_front: V_FRONT_RST[WIDTH-1:0],
        v_sync:   V_SYNC_RST[WIDTH-1:0],   v_back:  V_BACK_RST[WIDTH-1:0],
        hpol:     HPOL_RST,                vpol:    VPOL_RST
    };

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   ONE_X     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH+1:0] TOT_LIMIT = {2'b01, {WIDTH{1'b0}}};

    state_e           state_q, state_d;
    timing_t          act_q, act_d, pend_q, pend_d, cand;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             de_q, de_d, sof_q, sof_d, sol_q, sol_d;
    logic             running_q, running_d, cfg_err_q, cfg_err_d;

    logic [WIDTH:0]   h_act_start, h_act_end, h_tot;
    logic [WIDTH:0]   v_act_start, v_act_end, v_tot;
    logic [WIDTH+1:0] cand_h_tot, cand_v_tot;
    logic             cand_bad, run_now, h_last, v_last, frame_end;
    logic             sync_h, sync_v, act_h, act_v;

    assign cand = '{
        h_active: cfg.cfg_h_active, h_front: cfg.cfg_h_front,
        h_sync:   cfg.cfg_h_sync,   h_back:  cfg.cfg_h_back,
        v_active: cfg.cfg_v_active, v_front: cfg.cfg_v_front,
        v_sync:   cfg.cfg_v_sync,   v_back:  cfg.cfg_v_back,
        hpol:     cfg.cfg_hpol,     vpol:    cfg.cfg_vpol
    };

    // Region boundaries of the active set, one bit wider than the counters.
    always_comb begin
        h_act_start = {1'b0, act_q.h_sync} + {1'b0, act_q.h_back};
        h_act_end   = h_act_start + {1'b0, act_q.h_active};
        h_tot       = h_act_end + {1'b0, act_q.h_front};
        v_act_start = {1'b0, act_q.v_sync} + {1'b0, act_q.v_back};
        v_act_end   = v_act_start + {1'b0, act_q.v_active};
        v_tot       = v_act_end + {1'b0, act_q.v_front};
    end

    // The candidate totals get two extra bits so four maximal fields
    // cannot wrap around and slip under the limit.
    always_comb begin
        cand_h_tot = {2'b00, cand.h_active} + {2'b00, cand.h_front}
                   + {2'b00, cand.h_sync} + {2'b00, cand.h_back};
        cand_v_tot = {2'b00, cand.v_active} + {2'b00, cand.v_front}
                   + {2'b00, cand.v_sync} + {2'b00, cand.v_back};
        cand_bad   = (cand.h_active == '0) || (cand.h_sync == '0) ||
                     (cand.v_active == '0) || (cand.v_sync == '0) ||
                     (cand_h_tot > TOT_LIMIT) || (cand_v_tot > TOT_LIMIT);
    end

    assign run_now   = (state_q != IDLE);
    assign h_last    = ({1'b0, h_cnt_q} == (h_tot - ONE_X));
    assign v_last    = ({1'b0, v_cnt_q} == (v_tot - ONE_X));
    assign frame_end = run_now && h_last && v_last;

    // Run-control FSM: DRAIN keeps counting until the frame completes, so
    // a brief enable drop during RUN leaves the raster untouched.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable)         state_d = RUN;
                else if (frame_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Raster counters; held at the origin while idle so a restart is clean.
    always_comb begin
        h_cnt_d = h_cnt_q + ONE;
        v_cnt_d = v_cnt_q;
        if (!run_now) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : (v_cnt_q + ONE);
        end
    end

    // Config path. Applying and accepting are mutually exclusive because
    // one needs the pending slot full and the other needs it empty, which
    // also keeps a set accepted on a frame end from being applied then.
    always_comb begin
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cfg_err_d    = 1'b0;
        if (pend_valid_q && (!run_now || frame_end)) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
        end else if (cfg.cfg_valid && !pend_valid_q) begin
            if (cand_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_d       = cand;
                pend_valid_d = 1'b1;
            end
        end
    end

    // Output decode of the current counters against the active set.
    always_comb begin
        sync_h    = (h_cnt_q < act_q.h_sync);
        sync_v    = (v_cnt_q < act_q.v_sync);
        act_h     = ({1'b0, h_cnt_q} >= h_act_start) && ({1'b0, h_cnt_q} < h_act_end);
        act_v     = ({1'b0, v_cnt_q} >= v_act_start) && ({1'b0, v_cnt_q} < v_act_end);
        x_d       = '0;
        y_d       = '0;
        de_d      = 1'b0;
        sof_d     = 1'b0;
        sol_d     = 1'b0;
        running_d = run_now;
        hsync_d   = ~act_q.hpol;
        vsync_d   = ~act_q.vpol;
        if (run_now) begin
            de_d    = act_h && act_v;
            hsync_d = ~(sync_h ^ act_q.hpol);
            vsync_d = ~(sync_v ^ act_q.vpol);
            sof_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
            if (de_d) begin
                x_d = h_cnt_q - h_act_start[WIDTH-1:0];
                y_d = v_cnt_q - v_act_start[WIDTH-1:0];
            end
            sol_d   = de_d && (x_d == '0);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q      <= IDLE;
            act_q        <= RST_SET;
            pend_q       <= RST_SET;
            pend_valid_q <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= ~HPOL_RST;
            vsync_q      <= ~VPOL_RST;
            de_q         <= 1'b0;
            sof_q        <= 1'b0;
            sol_q        <= 1'b0;
            running_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
            sof_q        <= sof_d;
            sol_q        <= sol_d;
            running_q    <= running_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign x             = x_q;
    assign y             = y_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign de            = de_q;
    assign sof           = sof_q;
    assign sol           = sol_q;
    assign running       = running_q;
    assign cfg.cfg_ready = ~pend_valid_q;
    assign cfg.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
// Scoreboard bench: a reference model, written in terms of a linear position
// within the frame, pushes the expected outputs for every clock edge into a
// queue; a monitor on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;
    localparam int W = 12;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         hsync;
        logic         vsync;
        logic         de;
        logic         sof;
        logic         sol;
        logic         running;
        logic         ready;
        logic         err;
    } obs_t;

    logic         clk_pixel = 1'b0;
    logic         reset;
    logic         enable;
    logic [W-1:0] x, y;
    logic         hsync, vsync, de, sof, sol, running;

    video_timing_gen_if #(.WIDTH(W)) cfgIf ();

    video_timing_gen #(.WIDTH(W)) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .enable    (enable),
        .cfg       (cfgIf),
        .x         (x),
        .y         (y),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .sof       (sof),
        .sol       (sol),
        .running   (running)
    );

    always #5 clk_pixel = ~clk_pixel;

    obs_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: whether the raster is counting, whether a stop
    // has been requested, position within the frame, active and pending sets.
    cfg_t defSet = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:1'b0, vp:1'b0};
    cfg_t actSet;
    cfg_t pendSet;
    bit   pendFull;
    bit   counting;
    bit   stopping;
    int   pos;

    function automatic bit cfgOk(input cfg_t c);
        return (c.ha != 0) && (c.hs != 0) && (c.va != 0) && (c.vs != 0) &&
               (c.ha + c.hf + c.hs + c.hb <= (1 << W)) &&
               (c.va + c.vf + c.vs + c.vb <= (1 << W));
    endfunction

    function automatic cfg_t randCfg(input bit mustBeValid);
        cfg_t c;
        int   lo;
        lo   = mustBeValid ? 1 : 0;
        c.ha = $urandom_range(5, lo);
        c.hf = $urandom_range(3, 0);
        c.hs = $urandom_range(3, lo);
        c.hb = $urandom_range(3, 0);
        c.va = $urandom_range(4, lo);
        c.vf = $urandom_range(2, 0);
        c.vs = $urandom_range(2, lo);
        c.vb = $urandom_range(2, 0);
        c.hp = 1'($urandom_range(1, 0));
        c.vp = 1'($urandom_range(1, 0));
        return c;
    endfunction

    // Model: expected outputs after this edge come from the state before it;
    // ready reflects the pending slot after it.
    always @(posedge clk_pixel) begin : model
        obs_t e;
        cfg_t cand;
        int   htot, vtot, h, v, hStart, vStart;
        bit   frameEnd, sh, sv;
        e = '0;
        if (reset) begin
            e.hsync  = 1'b1;
            e.vsync  = 1'b1;
            e.ready  = 1'b1;
            actSet   = defSet;
            pendFull = 1'b0;
            counting = 1'b0;
            stopping = 1'b0;
            pos      = 0;
        end else begin
            htot   = actSet.hs + actSet.hb + actSet.ha + actSet.hf;
            vtot   = actSet.vs + actSet.vb + actSet.va + actSet.vf;
            h      = pos % htot;
            v      = pos / htot;
            hStart = actSet.hs + actSet.hb;
            vStart = actSet.vs + actSet.vb;
            if (counting) begin
                e.running = 1'b1;
                e.de = (h >= hStart) && (h < hStart + actSet.ha) &&
                       (v >= vStart) && (v < vStart + actSet.va);
                if (e.de) begin
                    e.x = W'(h - hStart);
                    e.y = W'(v - vStart);
                end
                sh      = (h < actSet.hs);
                sv      = (v < actSet.vs);
                e.hsync = sh ? actSet.hp : !actSet.hp;
                e.vsync = sv ? actSet.vp : !actSet.vp;
                e.sof   = (pos == 0);
                e.sol   = e.de && (h == hStart);
            end else begin
                e.hsync = !actSet.hp;
                e.vsync = !actSet.vp;
            end
            frameEnd = counting && (pos == htot * vtot - 1);

            cand.ha = int'(cfgIf.cfg_h_active); cand.hf = int'(cfgIf.cfg_h_front);
            cand.hs = int'(cfgIf.cfg_h_sync);   cand.hb = int'(cfgIf.cfg_h_back);
            cand.va = int'(cfgIf.cfg_v_active); cand.vf = int'(cfgIf.cfg_v_front);
            cand.vs = int'(cfgIf.cfg_v_sync);   cand.vb = int'(cfgIf.cfg_v_back);
            cand.hp = cfgIf.cfg_hpol;           cand.vp = cfgIf.cfg_vpol;
            if (pendFull && (!counting || frameEnd)) begin
                actSet   = pendSet;
                pendFull = 1'b0;
            end else if (cfgIf.cfg_valid && !pendFull) begin
                if (cfgOk(cand)) begin
                    pendSet  = cand;
                    pendFull = 1'b1;
                end else begin
                    e.err = 1'b1;
                end
            end

            if (counting) pos = frameEnd ? 0 : pos + 1;
            if (!counting) begin
                if (enable) begin
                    counting = 1'b1;
                    stopping = 1'b0;
                end
            end else if (!stopping) begin
                if (!enable) stopping = 1'b1;
            end else if (enable) begin
                stopping = 1'b0;
            end else if (frameEnd) begin
                counting = 1'b0;
                stopping = 1'b0;
            end
            e.ready = !pendFull;
        end
        expQ.push_back(e);
    end

    // Compare one expected observation against the DUT outputs.
    task automatic checkOutput(input obs_t e);
        obs_t a;
        a = {x, y, hsync, vsync, de, sof, sol, running, cfgIf.cfg_ready, cfgIf.cfg_err};
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL outputs @%0t: got x=%0d y=%0d hs=%b vs=%b de=%b sof=%b sol=%b run=%b rdy=%b err=%b, expected x=%0d y=%0d hs=%b vs=%b de=%b sof=%b sol=%b run=%b rdy=%b err=%b",
                     $time, a.x, a.y, a.hsync, a.vsync, a.de, a.sof, a.sol, a.running, a.ready, a.err,
                     e.x, e.y, e.hsync, e.vsync, e.de, e.sof, e.sol, e.running, e.ready, e.err);
        end
    endtask

    always @(negedge clk_pixel) begin : monitor
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    // Drive inputs (from a falling edge) and hold them for a number of cycles.
    task automatic applyStimulus(input bit rst, input bit en, input bit vld,
                                 input cfg_t c, input int cycles);
        reset               = rst;
        enable              = en;
        cfgIf.cfg_valid     = vld;
        cfgIf.cfg_h_active  = c.ha[W-1:0];
        cfgIf.cfg_h_front   = c.hf[W-1:0];
        cfgIf.cfg_h_sync    = c.hs[W-1:0];
        cfgIf.cfg_h_back    = c.hb[W-1:0];
        cfgIf.cfg_v_active  = c.va[W-1:0];
        cfgIf.cfg_v_front   = c.vf[W-1:0];
        cfgIf.cfg_v_sync    = c.vs[W-1:0];
        cfgIf.cfg_v_back    = c.vb[W-1:0];
        cfgIf.cfg_hpol      = c.hp;
        cfgIf.cfg_vpol      = c.vp;
        repeat (cycles) @(negedge clk_pixel);
    endtask

    initial begin
        cfg_t tiny, wide, bad, big, edgeSet, pol, rc;
        bit   en;
        tiny    = '{ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1, hp:1'b0, vp:1'b0};
        wide    = tiny; wide.ha = 6; wide.hf = 1; wide.hs = 1; wide.hb = 1;
        bad     = wide; bad.ha = 0;
        big     = tiny; big.ha = 4093; big.hs = 1; big.hb = 2; big.hf = 1;
        edgeSet = tiny; edgeSet.ha = 4093; edgeSet.hs = 1; edgeSet.hb = 1; edgeSet.hf = 1;
        pol     = tiny; pol.hp = 1'b1; pol.vp = 1'b1;

        $display("[TB] reset and tiny mode");
        applyStimulus(1, 0, 0, tiny, 3);
        applyStimulus(0, 0, 0, tiny, 2);
        applyStimulus(0, 0, 1, tiny, 1);
        applyStimulus(0, 0, 0, tiny, 2);
        applyStimulus(0, 1, 0, tiny, 110);

        $display("[TB] boundary swap and rejected sets");
        applyStimulus(0, 1, 1, wide, 1);
        applyStimulus(0, 1, 0, wide, 150);
        applyStimulus(0, 1, 1, bad, 1);
        applyStimulus(0, 1, 0, bad, 30);
        applyStimulus(0, 1, 1, big, 1);
        applyStimulus(0, 1, 0, big, 20);

        $display("[TB] drain, restart and enable glitch");
        applyStimulus(0, 0, 0, tiny, 80);
        applyStimulus(0, 1, 0, tiny, 60);
        applyStimulus(0, 0, 0, tiny, 1);
        applyStimulus(0, 1, 0, tiny, 60);

        $display("[TB] polarity");
        applyStimulus(0, 1, 1, pol, 1);
        applyStimulus(0, 1, 0, pol, 120);
        applyStimulus(0, 0, 0, pol, 80);

        $display("[TB] limit-sized set, mid-frame reset, start after reset");
        applyStimulus(0, 1, 0, pol, 7);
        applyStimulus(0, 1, 1, edgeSet, 1);
        applyStimulus(0, 1, 0, edgeSet, 20);
        applyStimulus(1, 1, 0, tiny, 2);
        applyStimulus(0, 1, 0, tiny, 20);

        $display("[TB] randomized episodes");
        for (int ep = 0; ep < 8; ep++) begin
            applyStimulus(1, 0, 0, tiny, 1);
            rc = randCfg(1'b1);
            applyStimulus(0, 0, 1, rc, 1);
            applyStimulus(0, 0, 0, rc, 2);
            en = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(29, 0) == 0) en = !en;
                if ($urandom_range(9, 0) == 0) begin
                    rc = randCfg(1'b0);
                    applyStimulus(0, en, 1, rc, 1);
                end else begin
                    applyStimulus(0, en, 0, rc, 1);
                end
            end
        end

        applyStimulus(0, 0, 0, tiny, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
